// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: turns the 3-bit RGB on/off pattern from the blink sequencer
// into three PWM LED drives whose brightness ramps toward the target level,
// so colour changes cross-fade instead of switching hard.
module rgb_pwm_fader #(
    parameter int PWM_BITS  = 8,
    parameter int MAX_DUTY  = 255,
    parameter int STEP_DIV  = 65536,
    parameter int FADE_STEP = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [2:0]              RGB_IN,
    input  logic                    EN,
    output logic [2:0]              LED_PWM,
    output logic                    BUSY,
    output logic [3*PWM_BITS-1:0]   DUTY_OBS
);

    // Step counter needs at least one bit even when every clock is a step.
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    localparam logic [PWM_BITS-1:0] MAX_D     = PWM_BITS'(MAX_DUTY);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'(MAX_DUTY - 1);
    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_DIV - 1);

    // A step larger than full scale behaves exactly like a full-scale step,
    // so clamp it once here to keep the widened arithmetic in range.
    localparam int                  FS_CLAMP  = (FADE_STEP > MAX_DUTY) ? MAX_DUTY : FADE_STEP;
    localparam logic [PWM_BITS:0]   FS_W      = (PWM_BITS + 1)'(FS_CLAMP);

    // One fade step of a single channel: move toward the target by at most
    // FS_W, never crossing it. One extra bit keeps the sum from wrapping and
    // the down path compares the gap first so it cannot underflow.
    function automatic logic [PWM_BITS-1:0] ramp_next(
        input logic [PWM_BITS-1:0] duty,
        input logic [PWM_BITS-1:0] tgt
    );
        logic [PWM_BITS:0] d_w;
        logic [PWM_BITS:0] t_w;
        logic [PWM_BITS:0] sum_w;
        logic [PWM_BITS:0] gap_w;
        d_w   = {1'b0, duty};
        t_w   = {1'b0, tgt};
        sum_w = d_w + FS_W;
        gap_w = d_w - t_w;
        if (d_w < t_w) begin
            if (sum_w > t_w) begin
                ramp_next = tgt;
            end else begin
                ramp_next = sum_w[PWM_BITS-1:0];
            end
        end else if (d_w > t_w) begin
            if (gap_w <= FS_W) begin
                ramp_next = tgt;
            end else begin
                ramp_next = duty - FS_W[PWM_BITS-1:0];
            end
        end else begin
            ramp_next = duty;
        end
    endfunction

    logic [2:0]                 rgb_q,      rgb_d;
    logic [PWM_BITS-1:0]        pwm_cnt_q,  pwm_cnt_d;
    logic [SW-1:0]              step_cnt_q, step_cnt_d;
    logic [2:0][PWM_BITS-1:0]   duty_q,     duty_d;
    logic [2:0][PWM_BITS-1:0]   duty_act_q, duty_act_d;
    logic [2:0]                 led_q,      led_d;
    logic                       busy_q,     busy_d;

    logic [2:0][PWM_BITS-1:0]   target_s;
    logic                       step_tick_s;
    logic                       boundary_s;

    // Next-state logic: counters, ramp steps, period-boundary duty load and PWM compare.
    always_comb begin
        rgb_d       = RGB_IN;
        step_tick_s = (step_cnt_q == STEP_LAST);
        boundary_s  = (pwm_cnt_q == PWM_LAST);
        busy_d      = 1'b0;

        if (boundary_s) begin
            pwm_cnt_d = '0;
        end else begin
            pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        end

        // The divider free-runs so EN only gates the ramp, not the step cadence.
        if (step_tick_s) begin
            step_cnt_d = '0;
        end else begin
            step_cnt_d = step_cnt_q + SW'(1);
        end

        for (int i = 0; i < 3; i++) begin
            if (rgb_q[i]) begin
                target_s[i] = MAX_D;
            end else begin
                target_s[i] = '0;
            end

            if (duty_q[i] != target_s[i]) begin
                busy_d = 1'b1;
            end else begin
                busy_d = busy_d;
            end

            // Output compares against the applied duty only, so a ramp step
            // landing mid-period cannot create a runt pulse.
            led_d[i] = (pwm_cnt_q < duty_act_q[i]);

            // The applied duty takes the pre-step ramp value even when a step
            // lands on the boundary edge; the new value waits a period.
            if (boundary_s) begin
                duty_act_d[i] = duty_q[i];
            end else begin
                duty_act_d[i] = duty_act_q[i];
            end

            if (step_tick_s && EN) begin
                duty_d[i] = ramp_next(duty_q[i], target_s[i]);
            end else begin
                duty_d[i] = duty_q[i];
            end
        end
    end

    // State registers with synchronous reset; reset wins over any step in progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rgb_q      <= 3'b000;
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            duty_q     <= '0;
            duty_act_q <= '0;
            led_q      <= 3'b000;
            busy_q     <= 1'b0;
        end else begin
            rgb_q      <= rgb_d;
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            duty_q     <= duty_d;
            duty_act_q <= duty_act_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
        end
    end

    assign LED_PWM  = led_q;
    assign BUSY     = busy_q;
    assign DUTY_OBS = duty_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Self-checking bench for rgb_pwm_fader: a cycle model predicts every output
// into a scoreboard queue as stimulus is driven; a monitor pops and compares
// after each edge. Directed checks cover ramp values, latencies and PWM shape.
module tb_rgb_pwm_fader;

    localparam int PB = 8;
    localparam int MD = 255;
    localparam int SD = 4;
    localparam int FS = 16;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [2:0]     RGB_IN = 3'b111;
    logic           EN = 1'b1;
    logic [2:0]     LED_PWM;
    logic           BUSY;
    logic [3*PB-1:0] DUTY_OBS;

    rgb_pwm_fader #(
        .PWM_BITS (PB),
        .MAX_DUTY (MD),
        .STEP_DIV (SD),
        .FADE_STEP(FS)
    ) u_dut (
        .CLK     (CLK),
        .RST     (RST),
        .RGB_IN  (RGB_IN),
        .EN      (EN),
        .LED_PWM (LED_PWM),
        .BUSY    (BUSY),
        .DUTY_OBS(DUTY_OBS)
    );

    // 10 ns clock
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0]  led;
        logic        busy;
        logic [23:0] duty;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_errors = 0;

    // Bench-side reference state
    int m_rgb  = 0;
    int m_pwm  = 0;
    int m_step = 0;
    int m_duty[3] = '{0, 0, 0};
    int m_act[3]  = '{0, 0, 0};
    bit m_led[3]  = '{1'b0, 1'b0, 1'b0};
    bit m_busy    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the reference by one edge for the given inputs and queue the
    // outputs the DUT must show after that edge.
    task automatic model_push(input logic rst, input logic [2:0] rgb, input logic en);
        int  tgt;
        int  nd;
        bit  tick;
        bit  bnd;
        bit  nbusy;
        exp_t e;
        if (rst) begin
            m_rgb = 0; m_pwm = 0; m_step = 0; m_busy = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_duty[i] = 0; m_act[i] = 0; m_led[i] = 1'b0;
            end
        end else begin
            tick  = (m_step == SD - 1);
            bnd   = (m_pwm == MD - 1);
            nbusy = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tgt = ((m_rgb >> i) & 1) != 0 ? MD : 0;
                nd  = m_duty[i];
                if (tick && en) begin
                    if (m_duty[i] < tgt)
                        nd = (m_duty[i] + FS > tgt) ? tgt : m_duty[i] + FS;
                    else if (m_duty[i] > tgt)
                        nd = (m_duty[i] - FS < tgt) ? tgt : m_duty[i] - FS;
                end
                m_led[i] = (m_pwm < m_act[i]);
                if (m_duty[i] != tgt) nbusy = 1'b1;
                if (bnd) m_act[i] = m_duty[i];
                m_duty[i] = nd;
            end
            m_busy = nbusy;
            m_pwm  = bnd  ? 0 : m_pwm + 1;
            m_step = tick ? 0 : m_step + 1;
            m_rgb  = int'(rgb);
        end
        e.led  = {m_led[2], m_led[1], m_led[0]};
        e.busy = m_busy;
        e.duty = {8'(m_duty[2]), 8'(m_duty[1]), 8'(m_duty[0])};
        sb_q.push_back(e);
    endtask

    // Drive one clock of stimulus; returns just after the edge has settled.
    task automatic drive(input logic rst, input logic [2:0] rgb, input logic en);
        @(negedge CLK);
        RST    = rst;
        RGB_IN = rgb;
        EN     = en;
        model_push(rst, rgb, en);
        @(posedge CLK);
        #2;
    endtask

    // Clock until the red duty changes (bounded), reporting clocks used.
    task automatic wait_step(input logic [2:0] rgb, input logic en, output int n);
        logic [7:0] prev;
        prev = DUTY_OBS[23:16];
        n = 0;
        do begin
            drive(1'b0, rgb, en);
            n++;
        end while (DUTY_OBS[23:16] == prev && n < 12);
    endtask

    // Count red high clocks over one full PWM period's worth of edges.
    task automatic count_high(input logic [2:0] rgb, input logic en, output int cnt);
        cnt = 0;
        repeat (MD) begin
            drive(1'b0, rgb, en);
            cnt += int'(LED_PWM[2]);
        end
    endtask

    // Scoreboard monitor: compare every queued prediction just after its edge.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check("sb_led",  32'(LED_PWM),  32'(mon_e.led));
                check("sb_busy", 32'(BUSY),     32'(mon_e.busy));
                check("sb_duty", 32'(DUTY_OBS), 32'(mon_e.duty));
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int cnt;

        // Reset held 3 clocks with all channels requested
        repeat (3) begin
            drive(1'b1, 3'b111, 1'b1);
            check("rst_led",  32'(LED_PWM),  32'd0);
            check("rst_busy", 32'(BUSY),     32'd0);
            check("rst_duty", 32'(DUTY_OBS), 32'd0);
        end
        wait_step(3'b111, 1'b1, n);
        check("first_step_clks", 32'(n), 32'd4);
        check("first_step_duty", 32'(DUTY_OBS[23:16]), 32'd16);

        // Rise of red only, clamped at full scale
        repeat (2) drive(1'b1, 3'b100, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            wait_step(3'b100, 1'b1, n);
            check("rise_duty", 32'(DUTY_OBS[23:16]), (k < 16) ? 32'(16 * k) : 32'd255);
            check("rise_gap",  32'(n), 32'd4);
        end
        check("rise_busy_hold", 32'(BUSY), 32'd1);
        drive(1'b0, 3'b100, 1'b1);
        check("rise_busy_drop", 32'(BUSY), 32'd0);
        check("rise_gb_zero",   32'(DUTY_OBS[15:0]), 32'd0);

        // Reversal at 128 back down to 0
        repeat (2) drive(1'b1, 3'b100, 1'b1);
        for (int k = 1; k <= 8; k++) wait_step(3'b100, 1'b1, n);
        check("rev_start", 32'(DUTY_OBS[23:16]), 32'd128);
        for (int k = 1; k <= 8; k++) begin
            wait_step(3'b000, 1'b1, n);
            check("rev_duty", 32'(DUTY_OBS[23:16]), 32'(128 - 16 * k));
        end
        repeat (8) drive(1'b0, 3'b000, 1'b1);
        check("rev_floor", 32'(DUTY_OBS[23:16]), 32'd0);
        check("rev_busy",  32'(BUSY), 32'd0);

        // PWM shape at duty 0
        repeat (2) drive(1'b1, 3'b000, 1'b1);
        count_high(3'b000, 1'b1, cnt);
        check("pwm_high_0", 32'(cnt), 32'd0);

        // PWM shape at duty 64 with the ramp frozen
        repeat (2) drive(1'b1, 3'b100, 1'b1);
        for (int k = 1; k <= 4; k++) wait_step(3'b100, 1'b1, n);
        check("pwm64_duty", 32'(DUTY_OBS[23:16]), 32'd64);
        repeat (260) drive(1'b0, 3'b100, 1'b0);
        count_high(3'b100, 1'b0, cnt);
        check("pwm_high_64", 32'(cnt), 32'd64);
        check("pwm64_frozen", 32'(DUTY_OBS[23:16]), 32'd64);

        // PWM shape at full scale
        for (int k = 1; k <= 12; k++) wait_step(3'b100, 1'b1, n);
        check("pwm255_duty", 32'(DUTY_OBS[23:16]), 32'd255);
        repeat (260) drive(1'b0, 3'b100, 1'b1);
        count_high(3'b100, 1'b1, cnt);
        check("pwm_high_255", 32'(cnt), 32'd255);

        // Freeze at 80 for 100 clocks, then a one-clock reset
        repeat (2) drive(1'b1, 3'b100, 1'b1);
        for (int k = 1; k <= 5; k++) wait_step(3'b100, 1'b1, n);
        repeat (100) begin
            drive(1'b0, 3'b100, 1'b0);
            check("frz_duty", 32'(DUTY_OBS[23:16]), 32'd80);
            check("frz_busy", 32'(BUSY), 32'd1);
        end
        drive(1'b1, 3'b100, 1'b0);
        check("mid_rst_led",  32'(LED_PWM),  32'd0);
        check("mid_rst_busy", 32'(BUSY),     32'd0);
        check("mid_rst_duty", 32'(DUTY_OBS), 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
